// File: rtl/game_sched_pkg.sv
// Shared types and constants for the target scheduler: FSM state encoding and
// the spawn direction classes the target sprite decodes from dir_sel.
package game_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpawn,
    StFly,
    StCooldown
  } sched_state_t;

  localparam logic [1:0] DIR_LR_DOWN   = 2'd0;
  localparam logic [1:0] DIR_RL_DOWN   = 2'd1;
  localparam logic [1:0] DIR_RAND_UP   = 2'd2;
  localparam logic [1:0] DIR_RAND_DOWN = 2'd3;

endpackage

// File: rtl/game_sched_level_ctr.sv
// Level escalation: counts wall hits and bumps speed every HITS_PER_LEVEL hits,
// saturating at MAX_SPEED. clr restarts the round at speed 1.
module game_sched_level_ctr #(
  parameter int unsigned HITS_PER_LEVEL = 5,
  parameter int unsigned SPEED_W        = 4,
  parameter int unsigned MAX_SPEED      = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [SPEED_W-1:0] speed
);

  localparam int unsigned HitW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  logic [HitW-1:0]    hit_cnt_q, hit_cnt_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    speed_d   = speed_q;
    if (clr) begin
      hit_cnt_d = '0;
      speed_d   = SPEED_W'(1);
    end else if (inc) begin
      if (hit_cnt_q == HitW'(HITS_PER_LEVEL - 1)) begin
        hit_cnt_d = '0;
        if (speed_q != SPEED_W'(MAX_SPEED)) begin
          speed_d = speed_q + 1'b1;
        end
      end else begin
        hit_cnt_d = hit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q <= '0;
      speed_q   <= SPEED_W'(1);
    end else begin
      hit_cnt_q <= hit_cnt_d;
      speed_q   <= speed_d;
    end
  end

  assign speed = speed_q;

endmodule

// File: rtl/game_target_scheduler.sv
// Target sprite life-cycle sequencer: spawn, flight, wall-hit cooldown, game over.
// Define GAME_SCHED_SCORE_SAT_EN to make score saturate instead of wrapping.
module game_target_scheduler
  import game_sched_pkg::*;
#(
  parameter int unsigned HITS_PER_LEVEL  = 5,
  parameter int unsigned SPEED_W         = 4,
  parameter int unsigned MAX_SPEED       = 15,
  parameter int unsigned COOLDOWN_CYCLES = 1024,
  parameter int unsigned SCORE_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               hit_wall,
  input  logic               collision,
  input  logic [7:0]         random,
  output logic               spawn_xy,
  output logic               spawn_dxy,
  output logic [1:0]         dir_sel,
  output logic [5:0]         spawn_off,
  output logic [SPEED_W-1:0] speed,
  output logic               target_enable,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               busy
);

  localparam int unsigned CntW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  sched_state_t       state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic               game_over_q, game_over_d;
  logic               hit_wall_q, hit_edge;
  logic [1:0]         dir_sel_q;
  logic [5:0]         spawn_off_q;
  logic               lvl_inc, lvl_clr;

  assign hit_edge = hit_wall & ~hit_wall_q;

`ifdef GAME_SCHED_SCORE_SAT_EN
  assign score_inc = (&score_q) ? score_q : score_q + 1'b1;
`else
  assign score_inc = score_q + 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    game_over_d = 1'b0;
    lvl_inc     = 1'b0;
    lvl_clr     = 1'b0;
    if (abort) begin
      // Score and speed are kept so the master FSM can still show them.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_d = StSpawn;
        end
        StSpawn: state_d = StFly;
        StFly: begin
          // Collision wins over a simultaneous wall hit.
          if (collision) begin
            game_over_d = 1'b1;
            score_d     = '0;
            lvl_clr     = 1'b1;
            state_d     = StIdle;
          end else if (hit_edge) begin
            score_d = score_inc;
            lvl_inc = 1'b1;
            cnt_d   = CntW'(COOLDOWN_CYCLES - 1);
            state_d = StCooldown;
          end
        end
        StCooldown: begin
          if (cnt_q == '0) state_d = StSpawn;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
      hit_wall_q  <= 1'b0;
      dir_sel_q   <= DIR_LR_DOWN;
      spawn_off_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      hit_wall_q  <= hit_wall;
      if (state_q == StSpawn) begin
        dir_sel_q   <= random[7:6];
        spawn_off_q <= random[5:0];
      end
    end
  end

  game_sched_level_ctr #(
    .HITS_PER_LEVEL(HITS_PER_LEVEL),
    .SPEED_W       (SPEED_W),
    .MAX_SPEED     (MAX_SPEED)
  ) u_level_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (lvl_inc),
    .clr  (lvl_clr),
    .speed(speed)
  );

  assign spawn_xy      = (state_q == StSpawn);
  assign spawn_dxy     = (state_q == StSpawn);
  assign target_enable = (state_q == StFly);
  assign busy          = (state_q != StIdle);
  assign dir_sel       = dir_sel_q;
  assign spawn_off     = spawn_off_q;
  assign score         = score_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_game_target_scheduler.sv
// Directed bench: instance A uses default parameters (timing, collision, abort);
// instance B uses a short cooldown and 8-bit score for long hit sequences.
module tb_game_target_scheduler;

  logic clk, rst;
  logic [7:0] random;

  logic       a_start, a_abort, a_hit, a_coll;
  logic       a_spawn_xy, a_spawn_dxy, a_ten, a_go, a_busy;
  logic [1:0] a_dir;
  logic [5:0] a_off;
  logic [3:0] a_speed;
  logic [15:0] a_score;

  logic       b_start, b_abort, b_hit, b_coll;
  logic       b_spawn_xy, b_spawn_dxy, b_ten, b_go, b_busy;
  logic [1:0] b_dir;
  logic [5:0] b_off;
  logic [3:0] b_speed;
  logic [7:0] b_score;

  int checks = 0;
  int errors = 0;

  game_target_scheduler u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .hit_wall(a_hit),
    .collision(a_coll), .random(random), .spawn_xy(a_spawn_xy), .spawn_dxy(a_spawn_dxy),
    .dir_sel(a_dir), .spawn_off(a_off), .speed(a_speed), .target_enable(a_ten),
    .score(a_score), .game_over(a_go), .busy(a_busy)
  );

  game_target_scheduler #(
    .COOLDOWN_CYCLES(2),
    .SCORE_W        (8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .hit_wall(b_hit),
    .collision(b_coll), .random(random), .spawn_xy(b_spawn_xy), .spawn_dxy(b_spawn_dxy),
    .dir_sel(b_dir), .spawn_off(b_off), .speed(b_speed), .target_enable(b_ten),
    .score(b_score), .game_over(b_go), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One wall hit on B, then wait (bounded) for the respawned target.
  task automatic hit_b();
    logic ok;
    b_hit = 1'b1;
    @(negedge clk);
    b_hit = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_ten) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_respawn", 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    random = 8'h00;
    {a_start, a_abort, a_hit, a_coll} = '0;
    {b_start, b_abort, b_hit, b_coll} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_speed", 32'(a_speed), 32'd1);
    check("rst_score", 32'(a_score), 32'd0);
    check("rst_ten", 32'(a_ten), 32'd0);
    check("rst_spawn", 32'(a_spawn_xy), 32'd0);
    check("rst_dir", 32'(a_dir), 32'd0);
    check("rst_off", 32'(a_off), 32'd0);
    check("rst_go", 32'(a_go), 32'd0);

    // Start -> SPAWN one cycle later, latching random = C5.
    random  = 8'hC5;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("spawn_xy", 32'(a_spawn_xy), 32'd1);
    check("spawn_dxy", 32'(a_spawn_dxy), 32'd1);
    check("spawn_ten", 32'(a_ten), 32'd0);
    @(negedge clk);
    check("fly_spawn_xy", 32'(a_spawn_xy), 32'd0);
    check("fly_ten", 32'(a_ten), 32'd1);
    check("fly_dir", 32'(a_dir), 32'd3);
    check("fly_off", 32'(a_off), 32'h05);
    check("fly_speed", 32'(a_speed), 32'd1);
    check("fly_score", 32'(a_score), 32'd0);

    // Held hit_wall counts once; cooldown lasts 1024 cycles.
    random = 8'h3A;
    a_hit  = 1'b1;
    @(negedge clk);
    check("hit_score", 32'(a_score), 32'd1);
    check("cd_ten", 32'(a_ten), 32'd0);
    check("cd_busy", 32'(a_busy), 32'd1);
    check("cd_dir_held", 32'(a_dir), 32'd3);
    n = 0;
    for (int k = 1; k <= 1100; k++) begin
      if (k == 100) a_hit = 1'b0;
      @(negedge clk);
      if (a_spawn_xy) begin
        n = k;
        break;
      end
    end
    check("cooldown_len", 32'(n), 32'd1024);
    check("held_score", 32'(a_score), 32'd1);
    @(negedge clk);
    check("respawn_dir", 32'(a_dir), 32'd0);
    check("respawn_off", 32'(a_off), 32'h3A);
    check("respawn_ten", 32'(a_ten), 32'd1);

    // Collision together with a hit edge: collision wins.
    a_hit  = 1'b1;
    a_coll = 1'b1;
    @(negedge clk);
    check("go_pulse", 32'(a_go), 32'd1);
    check("go_busy", 32'(a_busy), 32'd0);
    check("go_score", 32'(a_score), 32'd0);
    check("go_speed", 32'(a_speed), 32'd1);
    a_hit  = 1'b0;
    a_coll = 1'b0;
    @(negedge clk);
    check("go_one_cycle", 32'(a_go), 32'd0);

    // start alongside abort is ignored.
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    check("start_abort_busy", 32'(a_busy), 32'd0);

    // Abort mid-cooldown keeps the score and raises no game_over.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    a_hit = 1'b1;
    @(negedge clk);
    a_hit = 1'b0;
    check("pre_abort_score", 32'(a_score), 32'd1);
    repeat (10) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_score", 32'(a_score), 32'd1);
    check("abort_go", 32'(a_go), 32'd0);
    @(negedge clk);
    check("abort_go_late", 32'(a_go), 32'd0);

    // Long hit sequence on B: escalation, speed saturation, score wrap/saturation.
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    @(negedge clk);
    check("b_fly", 32'(b_ten), 32'd1);
    for (int i = 1; i <= 256; i++) begin
      hit_b();
      if (i == 5) begin
        check("b5_score", 32'(b_score), 32'd5);
        check("b5_speed", 32'(b_speed), 32'd2);
      end
      if (i == 70) begin
        check("b70_score", 32'(b_score), 32'd70);
        check("b70_speed", 32'(b_speed), 32'd15);
      end
      if (i == 255) check("b255_score", 32'(b_score), 32'hFF);
    end
`ifdef GAME_SCHED_SCORE_SAT_EN
    check("b_score_top", 32'(b_score), 32'hFF);
`else
    check("b_score_top", 32'(b_score), 32'h00);
`endif
    check("b_speed_sat", 32'(b_speed), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
